// File: rtl/writeback_scoreboard.sv
// Issue-time hazard scheduler for a shared 2R/1W register file: per-register writeback countdowns,
// RAW/WAW/write-port stall generation, and a check of each register-file write against its schedule.
module writeback_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 6,
  parameter int CNT_W    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs1,
  input  logic                issue_use_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_use_rs2,
  input  logic [4:0]          issue_rd,
  input  logic                issue_wr_rd,
  input  logic [CNT_W-1:0]    issue_lat,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                sched_error
);

  localparam int              TAG_W     = 5;
  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];

  logic             raw1, raw2, waw, port_hit, rd_ok;
  logic             lat_legal, record, lat_error;
  logic             wb_early, wb_missed, wb_error;
  logic [CNT_W:0]   lat_plus1;

  // Hazard detection and issue decision.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    port_hit  = 1'b0;
    lat_plus1 = {1'b0, issue_lat} + 1'b1;
    rd_ok     = issue_wr_rd && (issue_rd != '0);
    raw1      = issue_use_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] != '0);
    raw2      = issue_use_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] != '0);
    waw       = rd_ok && (cnt[issue_rd] != '0);
    for (int r = 1; r < NUM_REGS; r++) begin
      if ({1'b0, cnt[r]} == lat_plus1) port_hit = 1'b1;
    end
    stall      = issue_valid && (raw1 || raw2 || waw || (rd_ok && port_hit));
    issue_fire = issue_valid && !stall;
    lat_legal  = (issue_lat != '0) && (issue_lat <= MAX_LAT_C);
    record     = issue_fire && rd_ok && !flush;
    lat_error  = issue_fire && rd_ok && !lat_legal;
  end

  // Write-port check: a write must land exactly when its countdown reads 1.
  always_comb begin
    wb_missed = 1'b0;
    wb_early  = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != ONE_C);
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cnt[r] == ONE_C && !(wb_valid && wb_rd == r[TAG_W-1:0])) wb_missed = 1'b1;
    end
    wb_error = !flush && (wb_early || wb_missed);
  end

  // Next-state countdowns: flush beats a new record, which beats the decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = (cnt[r] != '0) ? cnt[r] - ONE_C : '0;
      if (r == 0 || flush) begin
        cnt_next[r] = '0;
      end else if (record && issue_rd == r[TAG_W-1:0]) begin
        cnt_next[r] = lat_legal ? issue_lat : MAX_LAT_C;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the countdowns are live scheduling state, not storage, so they must be reset;
    // a stale non-zero entry would stall decode or trip the write check after power-up.
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_mask   <= '0;
      sched_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= only, so every register samples pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r]       <= cnt_next[r];
        busy_mask[r] <= (cnt_next[r] != '0);
      end
      sched_error <= sched_error || lat_error || wb_error;
    end
  end

endmodule
